// File: rtl/mult_seq.sv
// Sequential WIDTH x WIDTH multiplier: one WIDTH x CHUNK partial product per clock,
// sign handled by magnitude multiply plus a final conditional negate.
module mult_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int NSTEP = WIDTH / CHUNK;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam int PW    = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             neg;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    pp;
   logic [CHUNK-1:0] b_chunk;

   // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic sgn);
      return (sgn && (v < 0)) ? -v : v;
   endfunction

   function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   assign b_chunk = mag_b[int'(cnt) * CHUNK +: CHUNK];
   assign pp      = (PW'(mag_a) * PW'(b_chunk)) << (int'(cnt) * CHUNK);

   // Operand registers only matter once captured, so they carry no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         mag_a <= magnitude(a, is_signed);
         mag_b <= magnitude(b, is_signed);
         neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         acc     <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               acc <= acc + pp;
               if (cnt == CW'(NSTEP - 1)) begin
                  state <= FINISH;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FINISH: begin
               product <= apply_sign(acc, neg);
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq at 32x8 and 16x4; expected products are queued by the
// stimulus and compared by per-instance monitors whenever done pulses.
module tb_mult_seq;

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic        start32 = 1'b0, sg32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        busy32, done32;
   logic [63:0] prod32;

   logic        start16 = 1'b0, sg16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16;
   logic [31:0] prod16;

   logic [63:0] exp32[$];
   logic [31:0] exp16[$];

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clk = ~clk;

   mult_seq #(.WIDTH(32), .CHUNK(8)) u32 (
      .clk(clk), .reset(reset), .start(start32), .is_signed(sg32),
      .a(a32), .b(b32), .busy(busy32), .done(done32), .product(prod32));

   mult_seq #(.WIDTH(16), .CHUNK(4)) u16 (
      .clk(clk), .reset(reset), .start(start16), .is_signed(sg16),
      .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tot_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   always @(negedge clk) begin
      if (done32 === 1'b1) begin
         if (exp32.size() == 0) check("u32 unexpected done", 64'd1, 64'd0);
         else check("u32 product", prod32, exp32.pop_front());
      end
   end

   always @(negedge clk) begin
      if (done16 === 1'b1) begin
         if (exp16.size() == 0) check("u16 unexpected done", 64'd1, 64'd0);
         else check("u16 product", 64'(prod16), 64'(exp16.pop_front()));
      end
   end

   task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                       input logic [63:0] ev);
      int n;
      @(negedge clk);
      a32 = av; b32 = bv; sg32 = sv; start32 = 1'b1;
      exp32.push_back(ev);
      @(negedge clk);
      start32 = 1'b0;
      n = 0;
      while (busy32 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("u32 busy length", 64'(n), 64'd5);
      check("u32 done at end", 64'(done32), 64'd1);
      @(negedge clk);
      check("u32 done single", 64'(done32), 64'd0);
      check("u32 product hold", prod32, ev);
   endtask

   task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       input logic [31:0] ev);
      int n;
      @(negedge clk);
      a16 = av; b16 = bv; sg16 = sv; start16 = 1'b1;
      exp16.push_back(ev);
      @(negedge clk);
      start16 = 1'b0;
      n = 0;
      while (busy16 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("u16 busy length", 64'(n), 64'd5);
      check("u16 done at end", 64'(done16), 64'd1);
   endtask

   initial begin
      int n, t1, t2;
      #12;
      check("reset busy", 64'(busy32), 64'd0);
      check("reset done", 64'(done32), 64'd0);
      check("reset product", prod32, 64'd0);
      check("reset product16", 64'(prod16), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
      op32(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 64'h0000_0000_8000_0000);
      op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      op32(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
      op32(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
      op32(32'h8000_0000, 32'h0000_0001, 1'b0, 64'h0000_0000_8000_0000);
      op32(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
      op32(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
      op32(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 64'h0000_0000_0000_0000);

      // Start pulse during busy must be dropped.
      @(negedge clk);
      a32 = 32'd3; b32 = 32'd5; sg32 = 1'b0; start32 = 1'b1;
      exp32.push_back(64'd15);
      @(negedge clk);
      start32 = 1'b0;
      @(negedge clk);
      a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      n = 0;
      while (busy32 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("ignored start done", 64'(done32), 64'd1);
      repeat (10) @(negedge clk);
      check("ignored start busy", 64'(busy32), 64'd0);

      // Held start: back-to-back operations, done 6 cycles apart.
      a32 = 32'hFFFF_FFFE; b32 = 32'd3; sg32 = 1'b1; start32 = 1'b1;
      exp32.push_back(64'hFFFF_FFFF_FFFF_FFFA);
      exp32.push_back(64'h0000_0000_0000_2710);
      @(negedge clk);
      a32 = 32'd100; b32 = 32'd100; sg32 = 1'b0;
      n = 1; t1 = -1; t2 = -1;
      while (t2 < 0 && n < 40) begin
         if (done32) begin
            if (t1 < 0) begin
               t1 = n;
               check("held busy low in done", 64'(busy32), 64'd0);
            end else begin
               t2 = n;
               start32 = 1'b0;
            end
         end
         if (t2 < 0) begin
            @(negedge clk);
            n++;
            if (t1 == n - 1) check("held busy rises", 64'(busy32), 64'd1);
         end
      end
      start32 = 1'b0;
      check("held done spacing", 64'(t2 - t1), 64'd6);
      repeat (10) @(negedge clk);

      // Reset on the 3rd busy cycle aborts silently.
      a32 = 32'hFFFF_FFFF; b32 = 32'd2; sg32 = 1'b0; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort busy", 64'(busy32), 64'd0);
      check("abort done", 64'(done32), 64'd0);
      check("abort product", prod32, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("abort product stays", prod32, 64'd0);
      op32(32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);

      op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
      op16(16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
      op16(16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF);

      repeat (4) @(negedge clk);
      check("u32 queue drained", 64'(exp32.size()), 64'd0);
      check("u16 queue drained", 64'(exp16.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised multi-cycle integer multiplier; the successor to the fixed 32x32 sequential multiplier. It computes a WIDTH x WIDTH product, signed or unsigned per operation, using one WIDTH x CHUNK partial product per clock. It adds a one-cycle done pulse, and product is held stable between operations. It sits on the datapath behind a start/busy handshake, where it replaces the 32x32 unit when instantiated with WIDTH=32, CHUNK=8.

## Interface

- WIDTH, 32, operand width in bits; must be a multiple of CHUNK and at least 2*CHUNK
- CHUNK, 8, bits of b consumed per step; NSTEP = WIDTH/CHUNK
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0); deassertion is synchronous to clk externally
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands and result, 0 = unsigned; sampled with start
- a  in  WIDTH  multiplicand; sampled with start
- b  in  WIDTH  multiplier; sampled with start
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when product is updated
- product  out  2*WIDTH  result register; holds the last result until the next done

## Operation

- States are IDLE, RUN and FINISH. The step counter runs 0..NSTEP-1.
- Reset, asynchronous while reset=0: state=IDLE, busy=0, done=0, product=0, accumulator=0, counter=0.
- IDLE:
  - If start=1 at the edge, capture the operands and go to RUN.
  - On capture: if is_signed=1, store |a| and |b| as unsigned WIDTH-bit magnitudes and store neg = a[W-1]^b[W-1]. Otherwise store a and b unchanged with neg=0.
  - -2^(W-1) has magnitude 2^(W-1), which fits in WIDTH unsigned bits.
  - On capture, clear the accumulator.
- RUN, step k:
  - accumulator += (mag_a * mag_b[k*CHUNK +: CHUNK]) << (k*CHUNK), computed at 2*WIDTH bits with no overflow possible.
  - Leave RUN after step NSTEP-1 and go to FINISH.
- FINISH:
  - product <= neg ? -accumulator : accumulator (two's complement, 2*WIDTH bits).
  - Pulse done=1 and return to IDLE.
- start while busy=1 is ignored and is not queued. Inputs may change freely after the capture edge.
- Held start is accepted again on the first edge in IDLE, so back-to-back operations are possible.
- Reset mid-operation aborts the operation with no done pulse, and product returns to 0.
- product never shows intermediate values; it changes only on the FINISH edge or on reset.

## Timing

- Edge E0: start=1 is sampled in IDLE. busy is 1 after E0.
- Edges E1..E_NSTEP: RUN steps.
- Edge E_NSTEP+1: the FINISH edge.
  - After it, product is valid and done=1 for exactly one cycle.
  - busy=0 in that same cycle.
- busy is high for NSTEP+1 cycles. Latency from the start edge to valid product is NSTEP+2 edges.
  - WIDTH=32, CHUNK=8: busy is high for 5 cycles.
- busy and done are registered outputs; there is no combinational path from inputs to outputs.
- If start=1 on the cycle where done=1, it is accepted at the next edge.
  - Its busy rises directly as done falls, so busy is low only during the done cycle.

## Test plan

- Reset, then unsigned a=0xFFFFFFFF, b=0xFFFFFFFF, start for 1 cycle:
  - busy is high for exactly 5 cycles.
  - done pulses once.
  - product=0xFFFFFFFE00000001.
- Signed a=0xFFFFFFFF (-1), b=0x80000000 (-2^31) -> product=0x0000000080000000.
- Signed a=0x80000000, b=0x80000000 -> 0x4000000000000000.
- Same operand bits as the previous case but unsigned -> 0x4000000000000000.
- Signed a=0x80000000, b=1 -> 0xFFFFFFFF80000000.
- Unsigned a=0x80000000, b=1 -> 0x0000000080000000.
- Pulse start with new operands while busy:
  - The pulse is ignored and the result matches the first operands.
  - Hold start=1 continuously: two operations complete, and done pulses 6 cycles apart.
- Assert reset at the 3rd busy cycle:
  - busy=0, done=0 and product=0 immediately (asynchronously).
  - No done follows.
  - A new start after reset completes normally.
- WIDTH=16, CHUNK=4:
  - Unsigned 0xFFFF x 0xFFFF -> 0xFFFE0001 with busy high for 5 cycles.
  - Signed 0x8000 x 0x7FFF -> 0xC0008000.
